i2s_tx_frame_ctrl: RTL

//  Sequencer for the I2S transmit datapath, running in the aud_mclk domain.

---
 rtl/i2s_tx_frame_ctrl_if.sv | 12 +
 rtl/i2s_tx_frame_ctrl.sv | 104 ++++++++++
 2 files changed

// File: rtl/i2s_tx_frame_ctrl_if.sv
// i2s_tx_frame_ctrl_if: valid/ready read channel from the audio FIFO.
// Each transfer carries one sample and the channel it belongs to.
interface i2s_tx_frame_ctrl_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] s_tdata;
  logic              s_tid;
  logic              s_tvalid;
  logic              s_tready;
  modport master (output s_tdata, s_tid, s_tvalid, input s_tready);
  modport slave (input s_tdata, s_tid, s_tvalid, output s_tready);
endinterface

// File: rtl/i2s_tx_frame_ctrl.sv
// i2s_tx_frame_ctrl: I2S transmit sequencer (sclk/lrclk generation, per-slot FIFO fetch, serializer).
// Underflow and channel errors raise one-cycle pulses and set a sticky irq.
module i2s_tx_frame_ctrl #(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32,
  parameter int DIV_W  = 8
) (
  input  logic                 aud_mclk,
  input  logic                 aud_mrst_n,
  input  logic                 ctrl_enable,
  input  logic [DIV_W-1:0]     ctrl_sclk_div,
  input  logic                 irq_clr,
  i2s_tx_frame_ctrl_if.slave   s,
  output logic                 sclk_out,
  output logic                 lrclk_out,
  output logic                 sdata_0_out,
  output logic                 busy,
  output logic                 irq,
  output logic                 underflow,
  output logic                 ch_err
);
  localparam int BW = $clog2(SLOT_W);
  typedef enum logic [1:0] {IDLE, START, RUN, STOP} state_t;
  state_t            state_q;
  logic [DIV_W-1:0]  div_q, div_cnt_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [DATA_W-1:0] sr_q;
  logic sclk_q, lrclk_q, sdata_q, tready_q, busy_q, irq_q, uf_q, ce_q, first_q;
  logic tick, fall, slot_end, done, fetch;
  assign tick     = div_cnt_q == div_q - DIV_W'(1);
  assign fall     = (state_q == RUN || state_q == STOP) && tick && sclk_q;
  assign slot_end = bit_cnt_q == BW'(SLOT_W - 1);
  assign done     = fall && state_q == STOP && !first_q && slot_end && lrclk_q;
  // The first fall after START opens the left slot; later fetches happen on slot wraps.
  assign fetch    = fall && (first_q || slot_end) && !done;
  always_ff @(posedge aud_mclk or negedge aud_mrst_n) begin
    if (!aud_mrst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      sclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      tready_q  <= 1'b0;
      busy_q    <= 1'b0;
      irq_q     <= 1'b0;
      uf_q      <= 1'b0;
      ce_q      <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      tready_q <= fetch;
      uf_q     <= tready_q && !s.s_tvalid;
      ce_q     <= tready_q && s.s_tvalid && (s.s_tid != lrclk_q);
      irq_q    <= uf_q || ce_q || (irq_q && !irq_clr);
      if (tready_q) sr_q <= s.s_tvalid ? s.s_tdata : '0;
      case (state_q)
        IDLE: if (ctrl_enable) begin
          state_q <= START;
          busy_q  <= 1'b1;
          div_q   <= (ctrl_sclk_div == '0) ? DIV_W'(1) : ctrl_sclk_div;
        end
        START: begin
          state_q   <= RUN;
          div_cnt_q <= '0;
          bit_cnt_q <= '0;
          sclk_q    <= 1'b0;
          lrclk_q   <= 1'b0;
          sdata_q   <= 1'b0;
          first_q   <= 1'b1;
        end
        default: begin
          if (state_q == RUN && !ctrl_enable) state_q <= STOP;
          div_cnt_q <= tick ? '0 : div_cnt_q + DIV_W'(1);
          if (tick) sclk_q <= !sclk_q;
          if (done) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            lrclk_q   <= 1'b0;
            sdata_q   <= 1'b0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            sr_q      <= '0;
          end else if (fall) begin
            first_q   <= 1'b0;
            bit_cnt_q <= fetch ? '0 : bit_cnt_q + BW'(1);
            sdata_q   <= fetch ? 1'b0 : sr_q[DATA_W-1];
            if (fetch) lrclk_q <= !first_q && !lrclk_q;
            else sr_q <= sr_q << 1;
          end
        end
      endcase
    end
  end
  assign s.s_tready  = tready_q;
  assign sclk_out    = sclk_q;
  assign lrclk_out   = lrclk_q;
  assign sdata_0_out = sdata_q;
  assign busy        = busy_q;
  assign irq         = irq_q;
  assign underflow   = uf_q;
  assign ch_err      = ce_q;
endmodule
